fetch_block_buffer: RTL and testbench

//  Fetch-stage queue between I-cache fetch-block return and inst_word_sel_mux.

---
 rtl/fetch_block_buffer.sv | 111 +++++++++++
 tb/tb_fetch_block_buffer.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_block_buffer.sv
// Fetch-block queue between I-cache return and the instruction word-select mux.
// Holds whole fetch blocks and tracks how far the mux has consumed the head block.
module fetch_block_buffer #(
  parameter int unsigned Xlen  = 32,
  parameter int unsigned Words = 4,
  parameter int unsigned Depth = 4,
  parameter int unsigned PcW   = 32,
  localparam int unsigned Iw   = $clog2(Words),
  localparam int unsigned Cw   = Iw + 1,
  localparam int unsigned Dw   = $clog2(Depth) + 1
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  flush_i,
  input  logic                  in_valid_i,
  output logic                  in_ready_o,
  input  logic [PcW-1:0]        in_pc_i,
  input  logic [Words*Xlen-1:0] in_block_i,
  output logic                  out_valid_o,
  output logic [Words*Xlen-1:0] out_block_o,
  output logic [PcW-1:0]        out_pc_o,
  output logic [Iw-1:0]         out_word_idx_o,
  output logic [Cw-1:0]         out_words_avail_o,
  input  logic [Cw-1:0]         consume_cnt_i,
  output logic [Dw-1:0]         count_o,
  output logic                  err_overconsume_o
);

  localparam int unsigned Pw = $clog2(Depth);

  logic [Words*Xlen-1:0] data_q [Depth];
  logic [PcW-Iw-3:0]     base_q [Depth];
  logic [Iw-1:0]         off_q  [Depth];
  logic [Iw-1:0]         off_d;
  logic [Pw-1:0]         head_q, head_d, tail_q, tail_d;
  logic [Dw-1:0]         count_q, count_d;
  logic                  err_q, err_d;
  logic                  push, consume, pop;
  logic [Cw-1:0]         avail;

  assign out_valid_o       = (count_q != '0);
  assign in_ready_o        = (count_q != Dw'(Depth));
  assign count_o           = count_q;
  assign err_overconsume_o = err_q;

  assign avail   = Cw'(Words) - Cw'(off_q[head_q]);
  assign push    = in_valid_i && in_ready_o && !flush_i;
  assign consume = out_valid_o && (consume_cnt_i != '0) && !flush_i;
  // Comparing against avail avoids the CW-bit wrap of offset + cnt on over-consume.
  assign pop     = consume && (consume_cnt_i >= avail);

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    err_d   = err_q | (consume && (consume_cnt_i > avail));
    off_d   = off_q[head_q] + consume_cnt_i[Iw-1:0];
    if (flush_i) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (pop) head_d = head_q + Pw'(1);
      if (push) tail_d = tail_q + Pw'(1);
      unique case ({push, pop})
        2'b10:   count_d = count_q + Dw'(1);
        2'b01:   count_d = count_q - Dw'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      err_q   <= 1'b0;
      for (int i = 0; i < int'(Depth); i++) begin
        data_q[i] <= '0;
        base_q[i] <= '0;
        off_q[i]  <= '0;
      end
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      err_q   <= err_d;
      if (push) begin
        data_q[tail_q] <= in_block_i;
        base_q[tail_q] <= in_pc_i[PcW-1:Iw+2];
        off_q[tail_q]  <= in_pc_i[2 +: Iw];
      end
      if (consume && !pop) off_q[head_q] <= off_d;
    end
  end

  always_comb begin
    out_block_o       = '0;
    out_pc_o          = '0;
    out_word_idx_o    = '0;
    out_words_avail_o = '0;
    if (out_valid_o) begin
      out_block_o       = data_q[head_q];
      out_pc_o          = {base_q[head_q], off_q[head_q], 2'b00};
      out_word_idx_o    = off_q[head_q];
      out_words_avail_o = avail;
    end
  end

endmodule

// File: tb/tb_fetch_block_buffer.sv
// Randomized bench for fetch_block_buffer against a queue-based model of the buffer.
// Directed sequences up front pin the model with literal expected values.
module tb_fetch_block_buffer;

  localparam int XLEN  = 32;
  localparam int WORDS = 4;
  localparam int DEPTH = 4;
  localparam int PC_W  = 32;

  logic                  clk = 1'b0;
  logic                  rst_n = 1'b0;
  logic                  flush = 1'b0;
  logic                  in_valid = 1'b0;
  logic                  in_ready;
  logic [PC_W-1:0]       in_pc = '0;
  logic [WORDS*XLEN-1:0] in_block = '0;
  logic                  out_valid;
  logic [WORDS*XLEN-1:0] out_block;
  logic [PC_W-1:0]       out_pc;
  logic [1:0]            out_word_idx;
  logic [2:0]            out_words_avail;
  logic [2:0]            consume_cnt = '0;
  logic [2:0]            count;
  logic                  err_overconsume;

  fetch_block_buffer dut (
    .clk_i             (clk),
    .rst_ni            (rst_n),
    .flush_i           (flush),
    .in_valid_i        (in_valid),
    .in_ready_o        (in_ready),
    .in_pc_i           (in_pc),
    .in_block_i        (in_block),
    .out_valid_o       (out_valid),
    .out_block_o       (out_block),
    .out_pc_o          (out_pc),
    .out_word_idx_o    (out_word_idx),
    .out_words_avail_o (out_words_avail),
    .consume_cnt_i     (consume_cnt),
    .count_o           (count),
    .err_overconsume_o (err_overconsume)
  );

  always #5 clk = ~clk;

  // Model: each entry keeps its block and the word-aligned PC of the next unconsumed word.
  typedef struct {
    logic [WORDS*XLEN-1:0] blk;
    logic [31:0]           pc;
  } ent_t;

  ent_t q[$];
  bit   m_err = 0;
  bit   chk_en = 0;
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int m_idx();
    return (q.size() == 0) ? 0 : int'((q[0].pc >> 2) % WORDS);
  endfunction

  function automatic int m_avail();
    return (q.size() == 0) ? 0 : WORDS - m_idx();
  endfunction

  task automatic model_clear();
    q.delete();
    m_err = 0;
  endtask

  // Advance the model by one clock edge using the inputs currently applied.
  task automatic model_step();
    bit   full;
    int   cc;
    ent_t e;
    if (flush) begin
      q.delete();
    end else begin
      full = (q.size() == DEPTH);
      cc   = int'(consume_cnt);
      if (q.size() > 0 && cc != 0) begin
        if (cc > m_avail()) m_err = 1;
        if (cc >= m_avail()) void'(q.pop_front());
        else q[0].pc = q[0].pc + 32'(4 * cc);
      end
      if (in_valid && !full) begin
        e.blk = in_block;
        e.pc  = in_pc & ~32'h3;
        q.push_back(e);
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic drive(input bit v, input logic [31:0] pc, input logic [2:0] cc, input bit fl);
    in_valid    = v;
    in_pc       = pc;
    in_block    = {$urandom, $urandom, $urandom, $urandom};
    consume_cnt = cc;
    flush       = fl;
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("out_valid", 128'(out_valid), 128'(q.size() != 0));
      chk("in_ready", 128'(in_ready), 128'(q.size() != DEPTH));
      chk("count", 128'(count), 128'(q.size()));
      chk("out_block", out_block, (q.size() != 0) ? q[0].blk : 128'h0);
      chk("out_pc", 128'(out_pc), (q.size() != 0) ? 128'(q[0].pc) : 128'h0);
      chk("out_word_idx", 128'(out_word_idx), 128'(m_idx()));
      chk("out_words_avail", 128'(out_words_avail), 128'(m_avail()));
      chk("err_overconsume", 128'(err_overconsume), 128'(m_err));
    end
  end

  initial begin
    int r;
    logic [2:0] cc;
    #12;
    rst_n = 1'b1;
    chk_en = 1;
    #1;
    chk("reset_count", 128'(count), 128'h0);
    chk("reset_in_ready", 128'(in_ready), 128'h1);

    // Async reset with three entries held.
    for (int i = 0; i < 3; i++) begin
      drive(1, 32'h100 + 32'(i * 16), 3'd0, 0);
      step();
    end
    drive(0, 0, 3'd0, 0);
    chk("pre_reset_count", 128'(count), 128'h3);
    #2;
    rst_n = 1'b0;
    model_clear();
    #1;
    chk("async_count", 128'(count), 128'h0);
    chk("async_out_valid", 128'(out_valid), 128'h0);
    chk("async_in_ready", 128'(in_ready), 128'h1);
    chk("async_out_pc", 128'(out_pc), 128'h0);
    chk("async_out_block", out_block, 128'h0);
    chk("async_avail", 128'(out_words_avail), 128'h0);
    #3;
    rst_n = 1'b1;

    // Push at a mid-block PC, then consume word by word into the next block.
    drive(1, 32'h1008, 3'd0, 0);
    step();
    chk("push_valid", 128'(out_valid), 128'h1);
    chk("push_idx", 128'(out_word_idx), 128'h2);
    chk("push_avail", 128'(out_words_avail), 128'h2);
    chk("push_pc", 128'(out_pc), 128'h1008);
    drive(1, 32'h1010, 3'd1, 0);
    step();
    chk("c1_idx", 128'(out_word_idx), 128'h3);
    chk("c1_pc", 128'(out_pc), 128'h100c);
    drive(0, 0, 3'd1, 0);
    step();
    chk("c2_pc", 128'(out_pc), 128'h1010);
    chk("c2_idx", 128'(out_word_idx), 128'h0);
    chk("c2_avail", 128'(out_words_avail), 128'h4);
    chk("c2_count", 128'(count), 128'h1);

    // Flush beats a simultaneous push and consume.
    drive(1, 32'h2000, 3'd0, 0);
    step();
    chk("pre_flush_count", 128'(count), 128'h2);
    drive(1, 32'h2010, 3'd2, 1);
    step();
    chk("flush_count", 128'(count), 128'h0);
    chk("flush_valid", 128'(out_valid), 128'h0);

    // Fill, then pop while full: the push is refused until the next cycle.
    for (int i = 0; i < 4; i++) begin
      drive(1, 32'h3000 + 32'(i * 16), 3'd0, 0);
      step();
    end
    chk("full_count", 128'(count), 128'h4);
    chk("full_ready", 128'(in_ready), 128'h0);
    drive(1, 32'h3040, 3'd4, 0);
    step();
    chk("full_pop_count", 128'(count), 128'h3);
    chk("full_pop_pc", 128'(out_pc), 128'h3010);
    drive(1, 32'h3040, 3'd0, 0);
    step();
    chk("refill_count", 128'(count), 128'h4);

    // Over-consume sets the sticky flag, which survives flush but not reset.
    drive(0, 0, 3'd0, 1);
    step();
    drive(1, 32'h4008, 3'd0, 0);
    step();
    drive(0, 0, 3'd3, 0);
    step();
    chk("oc_count", 128'(count), 128'h0);
    chk("oc_err", 128'(err_overconsume), 128'h1);
    drive(0, 0, 3'd0, 1);
    step();
    chk("oc_err_after_flush", 128'(err_overconsume), 128'h1);
    drive(0, 0, 3'd0, 0);
    #2;
    rst_n = 1'b0;
    model_clear();
    #1;
    chk("oc_err_after_reset", 128'(err_overconsume), 128'h0);
    #3;
    rst_n = 1'b1;

    // Randomized traffic with occasional flushes, over-consumes and async resets.
    for (int i = 0; i < 3000; i++) begin
      r = $urandom_range(0, 99);
      if (r < 35 || m_avail() == 0) cc = 3'd0;
      else if (r < 95) cc = 3'($urandom_range(1, m_avail()));
      else cc = 3'($urandom_range(1, 7));
      drive($urandom_range(0, 2) != 0, $urandom, cc, $urandom_range(0, 24) == 0);
      step();
      if (i % 400 == 200) begin
        #2;
        rst_n = 1'b0;
        model_clear();
        #3;
        rst_n = 1'b1;
      end
    end

    drive(0, 0, 3'd0, 0);
    step();
    chk_en = 0;
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
